mf_1bit_tx_framer: RTL and testbench

// - Transmit-side counterpart of the 1-bit matched-filter receiver. Emits a 1-bit chip stream with a
//   per-chip enable. Each frame is an L-chip PN preamble, then NW payload words serialised MSB first,

---
 rtl/mf_1bit_tx_framer.sv | 235 +++++++++++++++++++++++
 tb/tb_mf_1bit_tx_framer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mf_1bit_tx_framer.sv
// -----------------------------------------------------------------------------
// mf_1bit_tx_framer
//
// Purpose:
//   Transmit-side framer for the 1-bit matched-filter link. Each frame emits an
//   L-chip PN preamble (Fibonacci LFSR), then NW payload words serialised MSB
//   first, then GAP idle cycles. x_out/en_o are registered; the first chip
//   appears one cycle after start is sampled in IDLE.
//
// Build option:
//   TX_SCRAMBLE_EN  - when defined, payload chips are XORed with the LFSR, which
//                     keeps running from its end-of-preamble value and steps
//                     once per emitted payload chip. When undefined, payload
//                     chips are raw data bits and the LFSR holds during PAY.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   start       in   frame request, only sampled in IDLE
//   data_in     in   [DW] payload word
//   data_valid  in   data_in valid
//   data_ready  out  word accepted this cycle when data_valid is also high
//   x_out       out  chip value (registered)
//   en_o        out  x_out valid (registered)
//   busy        out  state != IDLE
//   frame_done  out  one-cycle pulse, high in the first IDLE cycle after a frame
//   underrun    out  one-cycle pulse per payload chip slot stalled for data
// -----------------------------------------------------------------------------
module mf_1bit_tx_framer #(
  parameter int              L       = 512,
  parameter int              PN_W    = 9,
  parameter logic [PN_W-1:0] PN_TAPS = 9'h110,
  parameter logic [PN_W-1:0] PN_SEED = 9'h1FF,
  parameter int              DW      = 16,
  parameter int              NW      = 4,
  parameter int              GAP     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  output logic          data_ready,
  output logic          x_out,
  output logic          en_o,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun
);

  localparam int CW = $clog2(L + 1);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int WW = $clog2(NW + 1);
  // +2 keeps the width non-zero when GAP is 0.
  localparam int GW = $clog2(GAP + 2);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [PN_W-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]   chip_cnt_q, chip_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]   word_cnt_q, word_cnt_d;
  logic [WW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic            buf_vld_q, buf_vld_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic            x_q, x_d;
  logic            en_q, en_d;
  logic            fd_q, fd_d;
  logic            und_q, und_d;

  logic            accept;
  logic            boundary;
  logic            have_word;
  logic [DW-1:0]   word_in;
  logic            stall;
  logic            emit_pay;
  logic            pay_bit;
  logic            last_pre;
  logic            last_pay;
  logic            last_gap;

  function automatic logic [PN_W-1:0] lfsr_step(input logic [PN_W-1:0] v);
    return {v[PN_W-2:0], ^(v & PN_TAPS)};
  endfunction

  assign accept    = data_valid && data_ready;
  assign boundary  = (state_q == S_PAY) && (bit_cnt_q == '0);
  assign have_word = buf_vld_q || accept;
  // An empty buffer at a boundary lets the word being accepted pass straight
  // through into the shift register.
  assign word_in   = buf_vld_q ? buf_q : data_in;
  assign stall     = boundary && !have_word;
  assign emit_pay  = (state_q == S_PAY) && !stall;
  assign pay_bit   = boundary ? word_in[DW-1] : sh_q[DW-1];
  assign last_pre  = (state_q == S_PRE) && (chip_cnt_q == CW'(L - 1));
  assign last_pay  = emit_pay && (word_cnt_q == WW'(NW - 1)) && (bit_cnt_q == BW'(DW - 1));
  assign last_gap  = (state_q == S_GAP) && (gap_cnt_q == GW'(GAP - 1));

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= PN_SEED;
      chip_cnt_q <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      acc_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      sh_q       <= '0;
      x_q        <= 1'b0;
      en_q       <= 1'b0;
      fd_q       <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      chip_cnt_q <= chip_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      sh_q       <= sh_d;
      x_q        <= x_d;
      en_q       <= en_d;
      fd_q       <= fd_d;
      und_q      <= und_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_PRE;
      S_PRE:   if (last_pre) state_d = S_PAY;
      S_PAY:   if (last_pay) state_d = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (last_gap) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    lfsr_d     = lfsr_q;
    chip_cnt_d = chip_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    sh_d       = sh_q;
    x_d        = 1'b0;
    en_d       = 1'b0;
    fd_d       = 1'b0;
    und_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d     = PN_SEED;
          chip_cnt_d = '0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          acc_cnt_d  = '0;
          gap_cnt_d  = '0;
          buf_vld_d  = 1'b0;
        end
      end
      S_PRE: begin
        x_d        = lfsr_q[PN_W-1];
        en_d       = 1'b1;
        lfsr_d     = lfsr_step(lfsr_q);
        chip_cnt_d = chip_cnt_q + CW'(1);
      end
      S_PAY: begin
        if (stall) begin
          und_d = 1'b1;
        end else begin
          en_d = 1'b1;
`ifdef TX_SCRAMBLE_EN
          x_d    = pay_bit ^ lfsr_q[PN_W-1];
          lfsr_d = lfsr_step(lfsr_q);
`else
          x_d    = pay_bit;
`endif
          sh_d = boundary ? (word_in << 1) : (sh_q << 1);
          if (bit_cnt_q == BW'(DW - 1)) begin
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + WW'(1);
          end else begin
            bit_cnt_d  = bit_cnt_q + BW'(1);
          end
        end
        if (last_pay && (GAP == 0)) fd_d = 1'b1;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (last_gap) fd_d = 1'b1;
      end
      default: ;
    endcase

    // Holding buffer: fill on accept unless the word passes straight through,
    // drain when a boundary consumes it.
    if (accept) begin
      acc_cnt_d = acc_cnt_q + WW'(1);
      if (!boundary) begin
        buf_d     = data_in;
        buf_vld_d = 1'b1;
      end
    end
    if (boundary && buf_vld_q) buf_vld_d = 1'b0;
  end

  // Output logic
  always_comb begin
    busy       = (state_q != S_IDLE);
    data_ready = ((state_q == S_PRE) || (state_q == S_PAY)) && !buf_vld_q &&
                 (acc_cnt_q < WW'(NW));
  end

  assign x_out      = x_q;
  assign en_o       = en_q;
  assign frame_done = fd_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_mf_1bit_tx_framer.sv
module tb_mf_1bit_tx_framer;

  localparam int              L       = 512;
  localparam int              PN_W    = 9;
  localparam logic [PN_W-1:0] PN_TAPS = 9'h110;
  localparam logic [PN_W-1:0] PN_SEED = 9'h1FF;
  localparam int              DW      = 16;
  localparam int              NW      = 4;
  localparam int              GAP     = 8;
  localparam int              NCHIP   = L + NW * DW;
`ifdef TX_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          x_out;
  logic          en_o;
  logic          busy;
  logic          frame_done;
  logic          underrun;

  int nvec  = 0;
  int nfail = 0;

  logic [DW-1:0] words [NW];
  logic          chip_e [NCHIP];

  mf_1bit_tx_framer #(
    .L(L), .PN_W(PN_W), .PN_TAPS(PN_TAPS), .PN_SEED(PN_SEED),
    .DW(DW), .NW(NW), .GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .x_out(x_out),
    .en_o(en_o), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reset/control table: inputs for one clock, outputs expected after it.
  // exp = {x_out, en_o, busy, data_ready, frame_done, underrun}
  typedef struct {
    logic       rst_n;
    logic       start;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vt [12];

  function automatic logic [PN_W-1:0] ref_step(input logic [PN_W-1:0] v);
    return {v[PN_W-2:0], ^(v & PN_TAPS)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected chip stream for the current words[] contents.
  task automatic build_expected();
    logic [PN_W-1:0] lf;
    logic            b;
    lf = PN_SEED;
    for (int i = 0; i < L; i++) begin
      chip_e[i] = lf[PN_W-1];
      lf = ref_step(lf);
    end
    for (int j = 0; j < NW * DW; j++) begin
      b = words[j / DW][DW - 1 - (j % DW)];
      if (SCR) begin
        b  = b ^ lf[PN_W-1];
        lf = ref_step(lf);
      end
      chip_e[L + j] = b;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One frame; start sampled at edge 0. Word sw is withheld until sl cycles
  // after its boundary (sw < 0: no withholding). hold keeps start high.
  task automatic run_frame(input int sw, input int sl, input bit hold, input string tag);
    int       s, tend, w, pos, p, last;
    bit       acc;
    logic     e_en, e_x, e_und, e_fd, e_busy;
    s    = (sw >= 0) ? sl : 0;
    tend = NCHIP + s + GAP;
    last = hold ? tend + 2 : tend + 2;
    w    = 0;
    build_expected();
    for (int c = 0; c <= last; c++) begin
      start = hold ? 1'b1 : (c == 0);
      if (w < NW && (w != sw || c >= L + 1 + sw * DW + sl)) begin
        data_valid = 1'b1;
        data_in    = words[w];
      end else begin
        data_valid = 1'b0;
        data_in    = '0;
      end
      acc = data_valid && data_ready;
      @(posedge clk);
      #1;
      if (acc) w++;
      e_en = 0; e_x = 0; e_und = 0; e_fd = 0;
      e_busy = (c < tend);
      if (c >= 1 && c <= L) begin
        e_en = 1;
        e_x  = chip_e[c-1];
      end else if (c > L && c <= NCHIP + s) begin
        pos = c - L - 1;
        if (sw >= 0 && pos >= sw * DW && pos < sw * DW + sl) begin
          e_und = 1;
        end else begin
          p    = pos - ((sw >= 0 && pos >= sw * DW + sl) ? sl : 0);
          e_en = 1;
          e_x  = chip_e[L + p];
        end
      end
      if (c == tend) e_fd = 1;
      if (hold && c == tend + 1) e_busy = 1;
      if (hold && c == tend + 2) begin
        e_busy = 1;
        e_en   = 1;
        e_x    = 1;
      end
      chk($sformatf("%s c=%0d {en,x,und,fd,busy}", tag, c),
          {27'd0, en_o, x_out, underrun, frame_done, busy},
          {27'd0, e_en, e_x, e_und, e_fd, e_busy});
    end
    start      = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic run_abort();
    for (int c = 0; c <= L + 20; c++) begin
      start      = (c == 0);
      data_valid = 1'b1;
      data_in    = 16'hFFFF;
      @(posedge clk);
      #1;
    end
    chk("abort pre-reset en_o", {31'd0, en_o}, 32'd1);
    rst_n      = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
    #2;
    chk("abort in-reset {x,en,busy,rdy}", {28'd0, x_out, en_o, busy, data_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort idle c=%0d {x,en,busy}", c), {29'd0, x_out, en_o, busy}, 32'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;

    vt[0]  = '{1'b0, 1'b1, 6'b000000, "reset start=1 a"};
    vt[1]  = '{1'b0, 1'b1, 6'b000000, "reset start=1 b"};
    vt[2]  = '{1'b1, 1'b0, 6'b000000, "release idle a"};
    vt[3]  = '{1'b1, 1'b0, 6'b000000, "release idle b"};
    vt[4]  = '{1'b1, 1'b1, 6'b001100, "start to PRE"};
    vt[5]  = '{1'b1, 1'b0, 6'b111100, "chip 1"};
    vt[6]  = '{1'b1, 1'b1, 6'b111100, "chip 2 start ignored"};
    vt[7]  = '{1'b1, 1'b0, 6'b111100, "chip 3"};
    vt[8]  = '{1'b1, 1'b0, 6'b111100, "chip 4"};
    vt[9]  = '{1'b0, 1'b0, 6'b000000, "reset in PRE"};
    vt[10] = '{1'b1, 1'b0, 6'b000000, "idle after reset a"};
    vt[11] = '{1'b1, 1'b0, 6'b000000, "idle after reset b"};

    for (int i = 0; i < 12; i++) begin
      rst_n = vt[i].rst_n;
      start = vt[i].start;
      @(posedge clk);
      #1;
      chk(vt[i].name, {26'd0, x_out, en_o, busy, data_ready, frame_done, underrun},
          {26'd0, vt[i].exp});
    end

    words[0] = 16'hA5C3; words[1] = 16'h0F0F; words[2] = 16'hFFFF; words[3] = 16'h0001;
    do_reset();
    run_frame(-1, 0, 1'b0, "frame");
    do_reset();
    run_frame(2, 5, 1'b0, "underrun");
    do_reset();
    run_frame(-1, 0, 1'b1, "hold");
    do_reset();
    run_abort();
    for (int i = 0; i < NW; i++) words[i] = '0;
    do_reset();
    run_frame(-1, 0, 1'b0, "zeros");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
